// File: rtl/br_update_queue.sv
// br_update_queue: compacts up to LANES retired branches per cycle into a
// circular FIFO and drains one predictor counter update per cycle.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   commit_valid    per-lane retire strobe (lane 0 oldest)
//   commit_pc       per-lane branch PC
//   commit_taken    per-lane resolved direction
//   ready           a full LANES-wide group fits this cycle
//   pc_result       head entry PC (0 when empty)
//   br_result       head entry direction (0 when empty)
//   pc_result_load  head entry valid; predictor consumes it this cycle
//   count           current occupancy
//   overflow        sticky: a commit arrived while ready was low
module br_update_queue #(
    parameter int DEPTH = 8,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             commit_valid,
    input  logic [LANES-1:0][31:0]       commit_pc,
    input  logic [LANES-1:0]             commit_taken,
    output logic                         ready,
    output logic [31:0]                  pc_result,
    output logic                         br_result,
    output logic                         pc_result_load,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    // Registered state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Storage; not reset, occupancy alone says what is live
    logic [31:0] mem_pc_q [DEPTH];
    logic [31:0] mem_pc_d [DEPTH];
    logic        mem_tk_q [DEPTH];
    logic        mem_tk_d [DEPTH];

    // Enqueue datapath
    logic [CNT_W-1:0] n_valid;
    logic [PTR_W-1:0] lane_slot [LANES];
    logic [LANES-1:0] lane_we;
    logic             any_valid;
    logic             accept;
    logic             not_empty;
    logic             ready_c;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_comb begin
        not_empty = (count_q != '0);
        // Conservative: the same-cycle dequeue is not credited.
        ready_c   = ((DEPTH_C - count_q) >= LANES_C);
        any_valid = |commit_valid;
        accept    = ready_c & any_valid;
    end

    // ------------------------------------------------------------------
    // Lane compaction: each valid lane takes the slot after the
    // previous valid lane, so gaps between lanes are squeezed out.
    // ------------------------------------------------------------------
    always_comb begin
        n_valid = '0;
        lane_we = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_slot[i] = tail_q + n_valid[PTR_W-1:0];
            lane_we[i]   = accept & commit_valid[i];
            n_valid      = n_valid + CNT_W'(commit_valid[i]);
        end
    end

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            mem_pc_d[s] = mem_pc_q[s];
            mem_tk_d[s] = mem_tk_q[s];
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem_pc_d[lane_slot[i]] = commit_pc[i];
                mem_tk_d[lane_slot[i]] = commit_taken[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer / occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Predictor never stalls: a presented head is always consumed.
        if (not_empty) begin
            head_d = head_q + PTR_W'(1);
        end

        if (accept) begin
            tail_d = tail_q + n_valid[PTR_W-1:0];
        end

        // accept implies count <= DEPTH-LANES, so no wrap here.
        count_d = count_q
                + (accept ? n_valid : '0)
                - CNT_W'(not_empty);

        // Whole group dropped; flag stays until reset.
        if (any_valid && !ready_c) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            mem_pc_q[s] <= mem_pc_d[s];
            mem_tk_q[s] <= mem_tk_d[s];
        end
    end

    // ------------------------------------------------------------------
    // Outputs: combinational from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        ready          = ready_c;
        count          = count_q;
        overflow       = overflow_q;
        pc_result_load = not_empty;
        pc_result      = '0;
        br_result      = 1'b0;
        if (not_empty) begin
            pc_result = mem_pc_q[head_q];
            br_result = mem_tk_q[head_q];
        end
    end

endmodule

// File: tb/tb_br_update_queue.sv
// tb_br_update_queue: directed vectors for br_update_queue
// (reset, single, sparse, fill/wrap, overflow, async reset).
module tb_br_update_queue;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        commit_valid;
    logic [3:0][31:0]  commit_pc;
    logic [3:0]        commit_taken;
    logic              ready;
    logic [31:0]       pc_result;
    logic              br_result;
    logic              pc_result_load;
    logic [3:0]        count;
    logic              overflow;

    int vectors     = 0;
    int miscompares = 0;
    int sent;
    int drained;

    br_update_queue #(.DEPTH(8), .LANES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_taken   (commit_taken),
        .ready          (ready),
        .pc_result      (pc_result),
        .br_result      (br_result),
        .pc_result_load (pc_result_load),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid = '0;
        commit_pc    = '0;
        commit_taken = '0;
    endtask

    task automatic put_one(input logic [31:0] pc, input logic tk);
        idle();
        commit_valid    = 4'b0001;
        commit_pc[0]    = pc;
        commit_taken[0] = tk;
    endtask

    task automatic put_group(input logic [31:0] base,
                             input logic [3:0] tk);
        commit_valid = 4'hF;
        for (int i = 0; i < 4; i++)
            commit_pc[i] = base + 32'(4 * i);
        commit_taken = tk;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_load", 32'(pc_result_load), 0);
        chk("rst_ready", 32'(ready), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rel_count", 32'(count), 0);
        chk("rel_ovf", 32'(overflow), 0);
        chk("rel_pc", pc_result, 0);

        // Single commit
        put_one(32'h60, 1'b1);
        step();
        idle();
        chk("one_load", 32'(pc_result_load), 1);
        chk("one_pc", pc_result, 32'h60);
        chk("one_br", 32'(br_result), 1);
        chk("one_count", 32'(count), 1);
        step();
        chk("one_load2", 32'(pc_result_load), 0);
        chk("one_pc2", pc_result, 0);
        chk("one_count2", 32'(count), 0);

        // Sparse compaction, lanes 1 and 3
        idle();
        commit_valid    = 4'b1010;
        commit_pc[1]    = 32'h104;
        commit_pc[3]    = 32'h10C;
        commit_taken    = 4'b1000;
        step();
        idle();
        chk("sp_count0", 32'(count), 2);
        chk("sp_pc0", pc_result, 32'h104);
        chk("sp_br0", 32'(br_result), 0);
        step();
        chk("sp_count1", 32'(count), 1);
        chk("sp_pc1", pc_result, 32'h10C);
        chk("sp_br1", 32'(br_result), 1);
        step();
        chk("sp_count2", 32'(count), 0);
        chk("sp_load2", 32'(pc_result_load), 0);

        // Fill and wrap: three groups 0x0..0x2C, odd entries taken.
        // Head/tail start at 3, so the pointers wrap along the way.
        sent    = 0;
        drained = 0;
        for (int c = 0; c < 40; c++) begin
            if (pc_result_load) begin
                chk("wrap_pc", pc_result, 32'(drained * 4));
                chk("wrap_br", 32'(br_result), 32'(drained % 2));
                drained++;
            end
            if (ready && sent < 3) begin
                put_group(32'(sent * 16), 4'b1010);
                sent++;
            end else begin
                idle();
            end
            step();
            if (c == 0) begin
                chk("wrap_cnt4", 32'(count), 4);
                chk("wrap_rdy4", 32'(ready), 1);
            end
            if (c == 1) begin
                chk("bnd_cnt7", 32'(count), 7);
                chk("bnd_rdy0", 32'(ready), 0);
                chk("bnd_pc", pc_result, 32'h4);
            end
        end
        idle();
        chk("wrap_drained", 32'(drained), 12);
        chk("wrap_sent", 32'(sent), 3);
        chk("wrap_empty", 32'(count), 0);
        chk("wrap_noovf", 32'(overflow), 0);

        // Overflow: commit while ready=0 is dropped
        put_group(32'h200, 4'b0000);
        step();
        chk("ov_cnt4", 32'(count), 4);
        put_group(32'h210, 4'b0000);
        step();
        chk("ov_cnt7", 32'(count), 7);
        chk("ov_rdy0", 32'(ready), 0);
        chk("ov_flag0", 32'(overflow), 0);
        put_one(32'hDEAD0, 1'b1);
        step();
        idle();
        chk("ov_cnt6", 32'(count), 6);
        chk("ov_flag1", 32'(overflow), 1);
        for (int k = 0; k < 6; k++) begin
            chk("ov_drain", pc_result, 32'h208 + 32'(4 * k));
            step();
        end
        chk("ov_empty", 32'(pc_result_load), 0);
        chk("ov_held", 32'(overflow), 1);
        // Tail must not have moved on the dropped commit
        put_one(32'h300, 1'b0);
        step();
        idle();
        chk("ov_tail_pc", pc_result, 32'h300);
        chk("ov_held2", 32'(overflow), 1);

        // Async reset mid-cycle with entries queued
        put_group(32'h400, 4'b1111);
        step();
        idle();
        chk("ar_cnt_pre", 32'(count), 4);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_load", 32'(pc_result_load), 0);
        chk("ar_pc", pc_result, 0);
        chk("ar_br", 32'(br_result), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_ready", 32'(ready), 1);
        chk("ar_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First post-reset enqueue
        put_one(32'h500, 1'b1);
        step();
        idle();
        chk("pr_pc", pc_result, 32'h500);
        chk("pr_br", 32'(br_result), 1);
        chk("pr_cnt", 32'(count), 1);
        step();
        chk("pr_cnt0", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
